// File: rtl/fp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_pkg : shared binary32 constants, FSM state type and field helper |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package fp_pkg;

  localparam int FP_W   = 32;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // True for Inf/NaN encodings (all-ones exponent field).
  function automatic logic is_exp_ones(input logic [FP_W-1:0] x);
    return &x[FP_W-2 -: EXP_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_accumulate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_accumulate : stream sum-reduction controller around external fadd |
// | Optional: FP_ACCUMULATE_SPECIAL_EN adds sticky Inf/NaN 'invalid' flag |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module fp_accumulate
  import fp_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_data,
  output logic [FP_W-1:0]  fadd_a,
  output logic [FP_W-1:0]  fadd_b,
  input  logic [FP_W-1:0]  fadd_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_data,
`ifdef FP_ACCUMULATE_SPECIAL_EN
  output logic             invalid,
`endif
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [FP_W-1:0]  r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len_q;
  logic [LEN_W-1:0] w_len_m1;
  logic             w_accept;
  logic             w_last;

  // The adder sits outside; operands are driven straight from state and input.
  assign fadd_a   = r_acc;
  assign fadd_b   = in_data;

  assign w_accept = in_valid && (r_state == ACCUM);
  assign w_len_m1 = r_len_q - LEN_W'(1);
  assign w_last   = (r_cnt == w_len_m1);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = FP_ZERO;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = (len == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_accept && w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = r_acc;
        busy      = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef FP_ACCUMULATE_SPECIAL_EN
  logic r_invalid;
  assign invalid = r_invalid;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc     <= FP_ZERO;
      r_cnt     <= '0;
      r_len_q   <= '0;
`ifdef FP_ACCUMULATE_SPECIAL_EN
      r_invalid <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc <= FP_ZERO;
`ifdef FP_ACCUMULATE_SPECIAL_EN
            r_invalid <= 1'b0;
`endif
            if (len != '0) begin
              r_len_q <= len;
              r_cnt   <= '0;
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_cnt <= r_cnt + LEN_W'(1);
`ifdef FP_ACCUMULATE_SPECIAL_EN
            // Once poisoned, the accumulator ignores the adder for the rest of the stream.
            if (r_invalid || is_exp_ones(in_data)) begin
              r_acc     <= FP_QNAN;
              r_invalid <= 1'b1;
            end else begin
              r_acc <= fadd_out;
            end
`else
            r_acc <= fadd_out;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_accumulate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fp_accumulate : randomized + directed bench with reference model  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module tb_fp_accumulate;

  localparam int LEN_W = 8;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             start     = 1'b0;
  logic [LEN_W-1:0] len       = '0;
  logic             in_valid  = 1'b0;
  logic [31:0]      in_data   = '0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic [31:0]      fadd_a;
  logic [31:0]      fadd_b;
  logic [31:0]      fadd_out;
  logic             out_valid;
  logic [31:0]      out_data;
  logic             busy;
`ifdef FP_ACCUMULATE_SPECIAL_EN
  logic             invalid;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  // Truncating binary32 adder with denormals flushed to zero.
  function automatic logic [31:0] fadd_f(input logic [31:0] a, input logic [31:0] b);
    logic sa, sb, s;
    int ea, eb, e, p, d;
    logic [63:0] ma, mb, m;
    sa = a[31]; sb = b[31];
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
    if (ea == 255 && eb == 255) return (sa == sb) ? a : 32'h7FC00000;
    if (ea == 255) return a;
    if (eb == 255) return b;
    if (ea == 0 && eb == 0) return 32'h0;
    if (ea == 0) return b;
    if (eb == 0) return a;
    ma = {40'd0, 1'b1, a[22:0]} << 30;
    mb = {40'd0, 1'b1, b[22:0]} << 30;
    if (eb > ea) begin
      s = sa; sa = sb; sb = s;
      e = ea; ea = eb; eb = e;
      m = ma; ma = mb; mb = m;
    end
    d  = ea - eb;
    mb = (d > 63) ? 64'd0 : (mb >> d);
    e  = ea;
    if (sa == sb)      begin m = ma + mb; s = sa; end
    else if (ma >= mb) begin m = ma - mb; s = sa; end
    else               begin m = mb - ma; s = sb; end
    if (m == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    e = e + p - 53;
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return 32'h0;
    if (p >= 23) m = m >> (p - 23);
    else         m = m << (23 - p);
    return {s, e[7:0], m[22:0]};
  endfunction

  assign fadd_out = fadd_f(fadd_a, fadd_b);

  fp_accumulate #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .fadd_a    (fadd_a),
    .fadd_b    (fadd_b),
    .fadd_out  (fadd_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef FP_ACCUMULATE_SPECIAL_EN
    .invalid   (invalid),
`endif
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 = waiting for a request, 1 = collecting samples, 2 = holding result.
  int          m_mode = 0;
  int          m_need = 0;
  logic [31:0] m_sum  = 32'h0;
  logic        m_inv  = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode <= 0; m_need <= 0; m_sum <= 32'h0; m_inv <= 1'b0;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_sum <= 32'h0;
          m_inv <= 1'b0;
          if (len == 0) m_mode <= 2;
          else begin m_need <= int'(len); m_mode <= 1; end
        end
        1: if (in_valid) begin
          m_need <= m_need - 1;
          if (m_need == 1) m_mode <= 2;
`ifdef FP_ACCUMULATE_SPECIAL_EN
          if (m_inv || in_data[30:23] == 8'hFF) begin
            m_sum <= 32'h7FC00000; m_inv <= 1'b1;
          end else m_sum <= fadd_f(m_sum, in_data);
`else
          m_sum <= fadd_f(m_sum, in_data);
`endif
        end
        default: if (out_ready) m_mode <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  {31'd0, in_ready},  {31'd0, m_mode == 1});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_mode == 2});
      chk("busy",      {31'd0, busy},      {31'd0, m_mode != 0});
      chk("out_data",  out_data, (m_mode == 2) ? m_sum : 32'h0);
      chk("fadd_a",    fadd_a, m_sum);
      chk("fadd_b",    fadd_b, in_data);
`ifdef FP_ACCUMULATE_SPECIAL_EN
      chk("invalid",   {31'd0, invalid},   {31'd0, m_inv});
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [31:0] r;
    r = $urandom;
    r[30:23] = 8'(100 + $urandom_range(50));
    return r;
  endfunction

  task automatic run_stream(input int L, input logic [31:0] s[$], input bit vp[$],
                            input int gap_pct, input int hold, input bit use_lit,
                            input logic [31:0] lit, input bit noise_start);
    int idx = 0;
    int k = 0;
    bit got = 1'b0;
    start = 1'b1;
    len   = L[LEN_W-1:0];
    step();
    start = 1'b0;
    len   = LEN_W'($urandom);
    while (idx < L) begin
      bit v;
      if (k < vp.size()) v = vp[k];
      else               v = ($urandom_range(99) >= gap_pct);
      k++;
      in_valid = v;
      in_data  = v ? s[idx] : $urandom;
      if (v) idx++;
      start = noise_start && ($urandom_range(3) == 0);
      step();
    end
    in_valid = 1'b0;
    start    = 1'b0;
    for (int j = 0; j < 8 && !got; j++) begin
      @(negedge clk);
      got = out_valid;
    end
    chk("out_valid_timeout", {31'd0, got}, 32'd1);
    if (got && use_lit) chk("result", out_data, lit);
    repeat (hold) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s[$];
    bit          vp[$];
    int          L;

    rst_n = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;

    s = {32'h3F800000, 32'h40000000, 32'h40400000}; vp = {};
    run_stream(3, s, vp, 0, 0, 1'b1, 32'h40C00000, 1'b0);

    s = {32'h40000000, 32'hBF000000};
    run_stream(2, s, vp, 0, 1, 1'b1, 32'h3FC00000, 1'b0);

    s = {};
    run_stream(0, s, vp, 0, 2, 1'b1, 32'h00000000, 1'b0);

    s = {32'h3F800000, 32'h40000000, 32'h40400000}; vp = {1, 0, 0, 1, 0, 1};
    run_stream(3, s, vp, 0, 5, 1'b1, 32'h40C00000, 1'b1);

    // Abandon a stream midway with reset.
    start = 1'b1; len = 4; step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h3F800000; step();
    in_data = 32'h40000000; step();
    in_valid = 1'b0; rst_n = 1'b0; step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_fadd_a", fadd_a, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    step();
    s = {32'h3F800000}; vp = {};
    run_stream(1, s, vp, 0, 0, 1'b1, 32'h3F800000, 1'b0);

    s = {32'h3F800000, 32'h7F800000, 32'h3F800000};
`ifdef FP_ACCUMULATE_SPECIAL_EN
    run_stream(3, s, vp, 0, 0, 1'b1, 32'h7FC00000, 1'b0);
    chk("special_invalid", {31'd0, invalid}, 32'd1);
`else
    run_stream(3, s, vp, 0, 0, 1'b1, 32'h7F800000, 1'b0);
`endif

    for (int t = 0; t < 40; t++) begin
      L = $urandom_range(12);
      s.delete();
      for (int i = 0; i < L; i++) s.push_back(rnd_fp());
      run_stream(L, s, vp, 30, $urandom_range(3), 1'b0, 32'h0, 1'b1);
    end

    s.delete();
    for (int i = 0; i < 255; i++) s.push_back(rnd_fp());
    run_stream(255, s, vp, 0, 1, 1'b0, 32'h0, 1'b0);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_accumulate.md
Name: fp_accumulate

Overview:
- Sequential sum-reduction controller wrapped around the combinational single-precision adder (fadd).
- Accepts a length-N stream of IEEE-754 binary32 samples over a valid/ready handshake and drives the adder with (accumulator, sample).
- Captures the adder result each accepted cycle and presents the final sum on a valid/ready output port.
- Sits directly upstream of fadd (feeds a/b) and directly downstream of it (consumes out).

Parameters:
- LEN_W, 8, width of the sample-count field; maximum stream length is 2^LEN_W-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request to begin a reduction; sampled only in IDLE.
- len  input  LEN_W  number of samples in the stream; latched on accepted start.
- in_valid  input  1  in_data holds a sample.
- in_ready  output  1  block accepts a sample this cycle.
- in_data  input  32  binary32 sample.
- fadd_a  output  32  adder operand a (accumulator).
- fadd_b  output  32  adder operand b (sample).
- fadd_out  input  32  adder result, combinational from fadd_a/fadd_b.
- out_valid  output  1  out_data holds the final sum.
- out_ready  input  1  consumer takes the result.
- out_data  output  32  final sum.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: state=IDLE, acc=32'h0, cnt=0, len_q=0, in_ready=0, out_valid=0, out_data=32'h0, busy=0.
- fadd_a = acc and fadd_b = in_data, continuously and combinationally. No registered path through the adder.
- IDLE:
  - start=1 and len!=0: latch len_q=len, clear acc=0 and cnt=0, go to ACCUM.
  - start=1 and len==0: acc=0, go to DONE. Result is 32'h00000000.
  - start=0: remain in IDLE.
- ACCUM:
  - in_ready=1.
  - A sample is accepted on a cycle with in_valid & in_ready.
  - On accept: acc <= fadd_out and cnt <= cnt+1.
  - If the accept occurs with cnt==len_q-1, go to DONE on the same edge.
  - No accept means acc and cnt hold.
- DONE:
  - out_valid=1, out_data=acc, in_ready=0.
  - out_data is held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready, return to IDLE on that edge.
- Throughput and latency:
  - One sample per cycle.
  - out_valid rises one cycle after the last sample is accepted.
  - Zero-length request: out_valid rises one cycle after start.
- start in ACCUM or DONE is ignored. No queueing.
- Counter width is LEN_W. len_q-1 is computed in LEN_W bits and is used only when len_q!=0.
- Reset asserted mid-operation: abandon the stream, return to reset values next edge. A pending out_valid is dropped.
- Arithmetic is entirely fadd's: truncating, denormals treated as zero. The block adds no rounding.

Optional Feature:
- Macro: FP_ACCUMULATE_SPECIAL_EN.
- When defined:
  - Adds output invalid (1 bit). Reset 0, cleared on accepted start, valid with out_valid.
  - An accepted sample with exponent 8'hFF sets invalid sticky. acc is forced to 32'h7FC00000 and held there for the rest of the stream, regardless of fadd_out.
- When undefined:
  - No invalid port.
  - exponent-FF samples pass straight to fadd.

Decomposition:
- Shared package fp_pkg:
  - FP_W=32, EXP_W=8, FRAC_W=23.
  - FP_QNAN=32'h7FC00000, FP_ZERO=32'h0.
  - State enum {IDLE, ACCUM, DONE}.
  - Helper function is_exp_ones().
- fadd is instantiated at the parent level, not inside this block, so the adder can be shared or replaced.
- No further sub-module; the FSM and counter stay in one module.

Test Plan:
- start, len=3, samples 3F800000, 40000000, 40400000 back-to-back -> out_valid one cycle after third accept, out_data=40C00000 (6.0).
- len=2, samples 40000000, BF000000 -> out_data=3FC00000 (1.5).
- len=0 start -> DONE next cycle, out_data=00000000, in_ready never asserted.
- len=3 with in_valid gapped (1,0,0,1,0,1) and out_ready held low 5 cycles -> acc only changes on accepts; out_data stable 5 cycles; returns to IDLE on the out_ready edge.
- rst_n low for one cycle after 2 of 4 samples -> all outputs at reset values; a new start len=1 with 3F800000 yields 3F800000.
- With FP_ACCUMULATE_SPECIAL_EN: len=3, samples 3F800000, 7F800000, 3F800000 -> invalid=1, out_data=7FC00000. Without the macro, the same stream produces the plain fadd result with no invalid port.
